// File: rtl/ysyx_25030081_lsu.sv
// rtl/ysyx_25030081_lsu.sv - RV32 load/store unit, one outstanding access over a valid/ready data port
// Lane data and strobes are computed at request accept so the mem_* outputs come straight from flops.
module ysyx_25030081_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_size)
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        lane_wdata = req_wdata;
        lane_wstrb = 4'b1111;
      end
    endcase
    if (!req_wen) lane_wstrb = 4'b0000;
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          waddr_d = req_addr[31:2];
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
          rdata_d = 32'h0;
          err_d   = misaligned;
          state_d = misaligned ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = wen_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= 30'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_rready    = (state_q == S_WAIT);
  assign resp_valid    = (state_q == S_RESP);
  assign mem_addr      = {waddr_q, 2'b00};
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// tb/tb_ysyx_25030081_lsu.sv - table-driven checks of the load/store unit
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid, mem_rready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25030081_lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_wstrb;
    int          rs;
    int          vs;
    int          ps;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, output int lat, output logic [31:0] rd, output logic er,
                     output int nreq, output logic [31:0] ma, output logic [31:0] mw,
                     output logic [3:0] ms, output logic mwe, output int bad);
    int  k, rc, wc, pc;
    logic seen_req, done;
    logic [31:0] hold_rd;
    logic hold_er;
    lat = -1; rd = 32'hX; er = 1'bx; nreq = 0; ma = '0; mw = '0; ms = '0; mwe = 1'b0; bad = 0;
    rc = 0; wc = 0; pc = 0; seen_req = 1'b0; done = 1'b0; hold_rd = '0; hold_er = 1'b0;
    @(negedge clk);
    if (!req_ready) bad++;
    req_valid = 1'b1; req_wen = v.wen; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.mword;
    mem_req_ready = 1'b0; mem_rvalid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (mem_req_valid) begin
        if (!seen_req) begin
          seen_req = 1'b1; ma = mem_addr; mw = mem_wdata; ms = mem_wstrb; mwe = mem_wen;
        end else if (mem_addr !== ma || mem_wdata !== mw || mem_wstrb !== ms || mem_wen !== mwe) begin
          bad++;
        end
        mem_req_ready = (rc >= v.rs);
        if (mem_req_ready) nreq++;
        rc++;
      end else begin
        mem_req_ready = 1'b0;
      end
      if (mem_rready) begin
        mem_rvalid = (wc >= v.vs);
        wc++;
      end else begin
        mem_rvalid = 1'b1;
      end
      if (resp_valid) begin
        if (lat < 0) begin
          lat = k; hold_rd = resp_rdata; hold_er = resp_err; rd = resp_rdata; er = resp_err;
        end else if (resp_rdata !== hold_rd || resp_err !== hold_er) begin
          bad++;
        end
        resp_ready = (pc >= v.ps);
        pc++;
        if (resp_ready) done = 1'b1;
      end else begin
        resp_ready = 1'b0;
      end
      if ((mem_req_valid || mem_rready || resp_valid) && req_ready) bad++;
    end
    if (!done) lat = -1;
    @(posedge clk);
    #1 resp_ready = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat, nreq, bad;
    logic [31:0] rd, ma, mw;
    logic er, mwe;
    logic [3:0] ms;
    run(v, lat, rd, er, nreq, ma, mw, ms, mwe, bad);
    chk({tag, " rdata"}, rd, v.exp_rdata);
    chk({tag, " err"}, {31'h0, er}, {31'h0, v.exp_err});
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " mem_req_count"}, nreq, v.exp_err ? 0 : 1);
    chk({tag, " stability"}, bad, 0);
    if (!v.exp_err) begin
      chk({tag, " mem_addr"}, ma, v.exp_maddr);
      chk({tag, " mem_wdata"}, mw, v.exp_mwdata);
      chk({tag, " mem_wstrb"}, {28'h0, ms}, {28'h0, v.exp_wstrb});
      chk({tag, " mem_wen"}, {31'h0, mwe}, {31'h0, v.wen});
    end
    @(negedge clk);
    chk({tag, " req_ready after"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    vec_t lhu;
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 32'h8000_0004, 32'h0, 4'h0, 0, 0, 0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'h80FF_7F01, 32'h0000_0001, 1'b0, 3, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h80FF_7F01, 32'h0000_007F, 1'b0, 3, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0, 3, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0, 3, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 32'h0000_0080, 1'b0, 3, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 32'h0000_0200, 32'hABCD_ABCD, 4'hC, 0, 0, 0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0, 32'h0, 4'h0, 0, 0, 0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_1001, 32'h5555, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0, 32'h0, 4'h0, 0, 0, 0};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0, 32'h0, 4'h0, 0, 0, 0};
    vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0303, 32'h0000_00A5, 32'h0, 32'h0, 1'b0, 2, 32'h0000_0300, 32'hA5A5_A5A5, 4'h8, 0, 0, 0};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 3, 32'h0000_0400, 32'h0, 4'h0, 0, 0, 0};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_0402, 32'h0, 32'h8001_1234, 32'h0000_8001, 1'b0, 3, 32'h0000_0400, 32'h0, 4'h0, 0, 0, 0};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 2, 32'h0000_0500, 32'hCAFE_F00D, 4'hF, 0, 0, 0};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0, 8, 32'h0000_0600, 32'h0, 4'h0, 3, 2, 2};
    vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h0000_07FF, 32'h0000_005A, 32'h0, 32'h0, 1'b0, 5, 32'h0000_07FC, 32'h5A5A_5A5A, 4'h8, 3, 0, 2};
    vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0, 32'h0, 4'h0, 0, 0, 2};

    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("reset ctrl", {22'h0, req_ready, resp_valid, resp_err, mem_req_valid, mem_rready, mem_wen, mem_wstrb},
        {22'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Abandon a load in WAIT with an asynchronous reset between clock edges.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0704; req_wdata = 32'h1111_1111; mem_req_ready = 1'b1; mem_rvalid = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst in wait", {31'h0, mem_rready}, 32'h1);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ctrl", {22'h0, req_ready, resp_valid, resp_err, mem_req_valid, mem_rready, mem_wen, mem_wstrb},
        {22'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("midrst mem_addr", mem_addr, 32'h0);
    chk("midrst mem_wdata", mem_wdata, 32'h0);
    chk("midrst resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lhu = '{1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 3, 32'h0, 32'h0, 4'h0, 0, 0, 0};
    apply(lhu, "post-reset lhu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_lsu.md
# ysyx_25030081_lsu

Load/store unit for the RV32 core's execute/memory boundary. It accepts the effective address produced by the ALU (`alu_out` of the add path), plus the store data and access size from decode. It then runs one memory transaction over a valid/ready data-memory port, and returns sign- or zero-extended load data (or store completion) to writeback. Only one access is outstanding at a time. A misaligned access is reported as an error without touching memory.

## Interface
- DATA_WIDTH, 32, data and address width (only 32 supported)
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute presents a memory op
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend (LBU/LHU), 0 = sign-extend
- req_addr  in  32  effective address from ALU
- req_wdata  in  32  store data (rs2), low-aligned
- resp_valid  out  1  result available to writeback
- resp_ready  in  1  writeback consumes result
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size access
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}
- mem_wen  out  1  store request
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables; 0 for loads
- mem_rvalid  in  1  load data returned
- mem_rready  out  1  LSU accepts load data
- mem_rdata  in  32  full aligned word

## Operation
- The FSM has four states: IDLE, REQ, WAIT and RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch wen, size, unsigned, addr and wdata.
  - If misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size=11), go to RESP with err=1 and rdata=0.
  - Otherwise go to REQ.
- **REQ**
  - mem_req_valid=1. mem_addr, mem_wen, mem_wdata and mem_wstrb come from the latched fields and are held stable until the handshake.
  - On mem_req_ready, a store goes to RESP (it completes on acceptance) and a load goes to WAIT.
- **WAIT**
  - mem_rready=1.
  - On mem_rvalid, capture the extracted data and go to RESP.
- **RESP**
  - resp_valid=1. resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE.
- **Store lanes:** off=addr[1:0].
  - Byte: wstrb=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - Half: wstrb=4'b0011<<off, wdata={2{wdata[15:0]}}.
  - Word: wstrb=4'b1111, wdata unchanged.
- **Load extract:**
  - shifted = mem_rdata >> (off*8).
  - Byte result is shifted[7:0], half result is shifted[15:0], word result is the full word.
  - Byte and half results are extended from bit 7 or bit 15 unless req_unsigned.
  - req_unsigned is ignored for word loads.
- Address arithmetic is modulo 2^32; no bounds checking.
- The memory port ignores a mem_rvalid arriving outside WAIT, and never drops a beat inside WAIT.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req_valid=0, mem_rready=0, mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
- Reset mid-transaction abandons the access immediately; the memory subsystem shares rst_n.
- Minimum latency from the req handshake edge to resp_valid high:
  - Load: 3 cycles (REQ 1 cycle, WAIT 1 cycle).
  - Store: 2 cycles.
  - Misaligned: 1 cycle.
- Each memory stall cycle (mem_req_ready=0 or mem_rvalid=0) adds exactly one cycle.
- Back-to-back throughput: a new request is accepted no earlier than the cycle after the resp_valid/resp_ready handshake.
  - req_ready is not high in the same cycle as resp_valid.
- Outputs are decoded from registered state and latched fields. There is no combinational path from req_* to mem_*, or from mem_rdata to resp_rdata.

## Test plan
- **Aligned word load:** addr=0x8000_0004, mem_rdata=0xDEAD_BEEF, mem_req_ready/mem_rvalid always 1.
  - Expect mem_addr=0x8000_0004, mem_wstrb=0.
  - Expect resp_rdata=0xDEAD_BEEF and resp_err=0, with resp_valid 3 cycles after accept.
- **Byte loads, all offsets:** mem_rdata=0x80FF_7F01.
  - LB at offsets 0/1/2/3 → 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80.
  - LBU at offset 3 → 0x0000_0080.
- **Half store at offset 2:** wdata=0x1234_ABCD.
  - Expect mem_wdata=0xABCD_ABCD and mem_wstrb=4'b1100.
  - Expect resp_valid 2 cycles after accept, resp_rdata=0.
- **Misaligned cases:** LW at 0x1002 and SH at 0x1001.
  - Expect no mem_req_valid pulse, and resp_err=1 with resp_valid 1 cycle after accept.
  - Same result for size=11.
- **Backpressure:** mem_req_ready low for 3 cycles, mem_rvalid delayed 2 cycles, resp_ready low for 2 cycles.
  - Expect all mem_* and resp_* outputs held stable throughout and exactly one transaction performed.
  - Expect req_ready low until the resp handshake.
- **Reset mid-access:** assert rst_n low while in WAIT.
  - Outputs reach their reset values without waiting for a clock edge.
  - A subsequent LHU of 0xFFFF at offset 0 returns 0x0000_FFFF.
